// File: rtl/tri_fifo.sv
// Triangle buffer between the projection stage (writer) and the draw FSM (reader).
// Push-only write port with backpressure and sticky overflow; registered read data.
module tri_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned COORD_W = 10
) (
    input  logic                              Clk,
    input  logic                              Reset_n,
    input  logic                              flush,
    input  logic                              wr_en,
    input  logic [2:0][1:0][COORD_W-1:0]      wr_data,
    output logic                              fifo_full,
    output logic                              overflow,
    input  logic                              fifo_r,
    output logic [2:0][1:0][COORD_W-1:0]      triangle_data,
    output logic                              fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [2:0][1:0][COORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]             r_count;
    logic                         r_overflow;
    logic [2:0][1:0][COORD_W-1:0] r_tri;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    // Flags decode from the pre-edge count; a same-cycle pop never frees a slot.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == CNT_W'(0));
    assign w_push_ok = wr_en  & ~w_full;
    assign w_pop_ok  = fifo_r & ~w_empty;

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge Clk) begin
        if (Reset_n && !flush && w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tri      <= '0;
        end else if (flush) begin
            // New frame: drop contents but keep the last triangle on the output.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_tri    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign fifo_full     = w_full;
    assign fifo_empty    = w_empty;
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign triangle_data = r_tri;

endmodule
